// File: rtl/reg_pipe_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : reg_pipe_pkg
// Brief    : Shared defaults and helpers for the reg_pipe_elastic pipeline.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package reg_pipe_pkg;

   localparam int REG_PIPE_WIDTH = 64;
   localparam int REG_PIPE_DEPTH = 4;
   localparam int REG_PIPE_TAG_W = 4;

   // Width of an occupancy counter that must hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage : reg_pipe_pkg
`default_nettype wire

// File: rtl/reg_pipe_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : reg_pipe_stage
// Brief    : One elastic register stage: valid bit, data word and, when
//            REG_PIPE_PARITY_EN is defined, a parity bit travelling with it.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module reg_pipe_stage #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             en,
   input  logic             load,
   input  logic             vld_in,
   input  logic [WIDTH-1:0] data_in,
`ifdef REG_PIPE_PARITY_EN
   input  logic             par_in,
   output logic             par,
`endif
   output logic             vld,
   output logic [WIDTH-1:0] dat
);

   // Valid follows upstream on load; data only captures real words so a
   // bubble passing through leaves the previous contents intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= 1'b0;
         dat <= '0;
`ifdef REG_PIPE_PARITY_EN
         par <= 1'b0;
`endif
      end else if (flush) begin
         vld <= 1'b0;
      end else if (en && load) begin
         vld <= vld_in;
         if (vld_in) begin
            dat <= data_in;
`ifdef REG_PIPE_PARITY_EN
            par <= par_in;
`endif
         end
      end
   end

endmodule : reg_pipe_stage
`default_nettype wire

// File: rtl/reg_pipe_elastic.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : reg_pipe_elastic
// Brief    : DEPTH-stage bubble-collapsing elastic pipeline with valid/ready
//            on both sides, MSB tag export and occupancy count.
//            Optional parity checking under macro REG_PIPE_PARITY_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module reg_pipe_elastic
   import reg_pipe_pkg::*;
#(
   parameter int WIDTH = REG_PIPE_WIDTH,
   parameter int DEPTH = REG_PIPE_DEPTH,
   parameter int TAG_W = REG_PIPE_TAG_W
) (
   input  logic                          clk,
   input  logic                          R,
   input  logic                          E,
   input  logic                          FL,
   input  logic                          in_vld,
   output logic                          in_rdy,
   input  logic [WIDTH-1:0]              data,
   output logic                          out_vld,
   input  logic                          out_rdy,
   output logic [WIDTH-1:0]              q,
   output logic [TAG_W-1:0]              q_tag,
   output logic [cnt_width(DEPTH)-1:0]   cnt,
   output logic                          par_err
);

   localparam int CW = cnt_width(DEPTH);

   // Unpacked so each ready term is an independent net in the chain.
   logic             rdy    [DEPTH+1];
   logic             v      [DEPTH];
   logic [WIDTH-1:0] d      [DEPTH];
   logic             v_in   [DEPTH];
   logic [WIDTH-1:0] d_in   [DEPTH];
   logic             in_xfer;
   logic             out_xfer;

   assign rdy[DEPTH] = out_rdy;
   assign in_rdy     = rdy[0] & E & ~FL;
   assign out_vld    = v[DEPTH-1] & E;
   assign q          = d[DEPTH-1];
   assign q_tag      = q[WIDTH-1 -: TAG_W];
   assign in_xfer    = in_vld & in_rdy;
   assign out_xfer   = out_vld & out_rdy;

`ifdef REG_PIPE_PARITY_EN
   logic p    [DEPTH];
   logic p_in [DEPTH];
`endif

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
         // A stage can take a word if it is empty or its occupant moves on.
         assign rdy[i] = ~v[i] | rdy[i+1];

         if (i == 0) begin : g_head
            assign v_in[i] = in_vld;
            assign d_in[i] = data;
`ifdef REG_PIPE_PARITY_EN
            assign p_in[i] = ^data;
`endif
         end else begin : g_body
            assign v_in[i] = v[i-1];
            assign d_in[i] = d[i-1];
`ifdef REG_PIPE_PARITY_EN
            assign p_in[i] = p[i-1];
`endif
         end

         reg_pipe_stage #(
            .WIDTH   (WIDTH)
         ) u_stage (
            .clk     (clk),
            .rst     (R),
            .flush   (FL),
            .en      (E),
            .load    (rdy[i]),
            .vld_in  (v_in[i]),
            .data_in (d_in[i]),
`ifdef REG_PIPE_PARITY_EN
            .par_in  (p_in[i]),
            .par     (p[i]),
`endif
            .vld     (v[i]),
            .dat     (d[i])
         );
      end
   endgenerate

   // Occupancy moves only when exactly one side of the pipe transfers.
   always_ff @(posedge clk) begin
      if (R || FL) begin
         cnt <= '0;
      end else if (in_xfer && !out_xfer) begin
         cnt <= cnt + CW'(1);
      end else if (!in_xfer && out_xfer) begin
         cnt <= cnt - CW'(1);
      end
   end

`ifdef REG_PIPE_PARITY_EN
   // Sticky flag set when an emitted word disagrees with its stored parity.
   always_ff @(posedge clk) begin
      if (R || FL) begin
         par_err <= 1'b0;
      end else if (out_xfer && ((^q) != p[DEPTH-1])) begin
         par_err <= 1'b1;
      end
   end
`else
   assign par_err = 1'b0;
`endif

endmodule : reg_pipe_elastic
`default_nettype wire

// File: tb/tb_reg_pipe_elastic.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_reg_pipe_elastic
// Brief    : Self-checking scoreboard bench for reg_pipe_elastic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_reg_pipe_elastic;
   import reg_pipe_pkg::*;

   localparam int WIDTH = 64;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
   localparam int CW    = cnt_width(DEPTH);

   logic             clk = 1'b0;
   logic             R, E, FL, in_vld, in_rdy, out_vld, out_rdy, par_err;
   logic [WIDTH-1:0] data, q;
   logic [TAG_W-1:0] q_tag;
   logic [CW-1:0]    cnt;

   int               total = 0;
   int               bad   = 0;
   logic [WIDTH-1:0] exp_q [$];
   int               mcnt  = 0;

   reg_pipe_elastic #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .TAG_W   (TAG_W)
   ) dut (
      .clk     (clk),
      .R       (R),
      .E       (E),
      .FL      (FL),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .data    (data),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .q       (q),
      .q_tag   (q_tag),
      .cnt     (cnt),
      .par_err (par_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      out_rdy = 1'b1;
      in_vld  = 1'b0;
      @(negedge clk);
      while (cnt != 0 && n < 50) begin
         cyc();
         @(negedge clk);
         n++;
      end
      check("drain_cnt", cnt, 0);
      check("drain_queue", exp_q.size(), 0);
      cyc();
   endtask

   // Scoreboard: push on input transfer, pop and compare on output transfer.
   always @(negedge clk) begin
      if (R) begin
         exp_q.delete();
         mcnt = 0;
      end else begin
         check("cnt_model", cnt, mcnt);
         if (out_vld && out_rdy) begin
            check("out_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               logic [WIDTH-1:0] e;
               e = exp_q.pop_front();
               check("out_data", q, e);
               check("out_tag", q_tag, e[WIDTH-1 -: TAG_W]);
            end
            mcnt--;
         end
         if (in_vld && in_rdy) begin
            exp_q.push_back(data);
            mcnt++;
         end
         if (FL) begin
            exp_q.delete();
            mcnt = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int               lat;
      logic             found;
      logic [WIDTH-1:0] keep;
      logic [CW-1:0]    keep_cnt;

      // Reset with garbage on the input.
      R = 1'b1; E = 1'b1; FL = 1'b0; in_vld = 1'b1; data = '1; out_rdy = 1'b0;
      cyc(); cyc();
      @(negedge clk);
      check("rst_q", q, 0);
      check("rst_tag", q_tag, 0);
      check("rst_vld", out_vld, 0);
      check("rst_cnt", cnt, 0);
      check("rst_par", par_err, 0);
      cyc();
      R = 1'b0; in_vld = 1'b0;

      // Latency through an empty pipe.
      out_rdy = 1'b1; in_vld = 1'b1; data = 64'hA000_0000_0000_0001;
      cyc();
      in_vld = 1'b0;
      lat = 0; found = 1'b0;
      for (int k = 1; k <= 20 && !found; k++) begin
         @(negedge clk);
         if (out_vld) begin
            found = 1'b1;
            lat   = k;
         end else begin
            cyc();
         end
      end
      check("lat_cycles", lat, DEPTH);
      check("lat_tag", q_tag, 4'hA);
      cyc();
      drain();

      // Back-pressure: four accepts fill the pipe, fifth waits.
      out_rdy = 1'b0;
      for (int w = 1; w <= 4; w++) begin
         in_vld = 1'b1; data = WIDTH'(w);
         @(negedge clk);
         check("bp_accept", in_rdy, 1);
         cyc();
      end
      in_vld = 1'b1; data = 64'd5;
      @(negedge clk);
      check("bp_full_rdy", in_rdy, 0);
      check("bp_cnt", cnt, 4);
      cyc();
      @(negedge clk);
      check("bp_hold_rdy", in_rdy, 0);
      check("bp_head", q, 1);
      cyc();
      out_rdy = 1'b1;
      @(negedge clk);
      check("bp_release_rdy", in_rdy, 1);
      cyc();
      drain();

      // Bubble collapse.
      out_rdy = 1'b0; in_vld = 1'b1; data = 64'h0000_0000_0000_003C;
      cyc();
      in_vld = 1'b0;
      repeat (6) cyc();
      @(negedge clk);
      check("bub_cnt1", cnt, 1);
      check("bub_vld", out_vld, 1);
      cyc();
      for (int w = 0; w < 3; w++) begin
         in_vld = 1'b1; data = 64'h5000_0000_0000_0100 + WIDTH'(w);
         @(negedge clk);
         check("bub_accept", in_rdy, 1);
         cyc();
      end
      in_vld = 1'b0;
      @(negedge clk);
      check("bub_cnt4", cnt, 4);
      keep = q;

      // Flush a full pipe; the in-flight word is refused.
      cyc();
      FL = 1'b1; in_vld = 1'b1; data = 64'hDEAD;
      @(negedge clk);
      check("fl_in_rdy", in_rdy, 0);
      cyc();
      FL = 1'b0; in_vld = 1'b0;
      @(negedge clk);
      check("fl_cnt", cnt, 0);
      check("fl_vld", out_vld, 0);
      check("fl_q_kept", q, keep);
      check("fl_q_word", q, 64'h3C);
      cyc();

      // Enable low freezes everything mid-stream.
      out_rdy = 1'b0;
      for (int w = 0; w < 2; w++) begin
         in_vld = 1'b1; data = 64'hC000_0000_0000_0200 + WIDTH'(w);
         cyc();
      end
      E = 1'b0; in_vld = 1'b1; out_rdy = 1'b1;
      @(negedge clk);
      keep = q; keep_cnt = cnt;
      check("en_cnt2", cnt, 2);
      for (int k = 0; k < 3; k++) begin
         if (k != 0) @(negedge clk);
         check("en_in_rdy", in_rdy, 0);
         check("en_out_vld", out_vld, 0);
         check("en_cnt_hold", cnt, keep_cnt);
         check("en_q_hold", q, keep);
         cyc();
      end
      E = 1'b1; in_vld = 1'b0;
      drain();

      // Random traffic against the scoreboard.
      for (int k = 0; k < 400; k++) begin
         in_vld  = 1'($urandom_range(0, 1));
         out_rdy = ($urandom_range(0, 3) != 0);
         E       = ($urandom_range(0, 7) != 0);
         data    = {$urandom, $urandom};
         cyc();
      end
      E = 1'b1;
      drain();

      // Reset mid-stream.
      out_rdy = 1'b0;
      for (int w = 0; w < 3; w++) begin
         in_vld = 1'b1; data = 64'hF000_0000_0000_0300 + WIDTH'(w);
         cyc();
      end
      R = 1'b1; out_rdy = 1'b1; in_vld = 1'b1;
      cyc();
      R = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
      @(negedge clk);
      check("mrst_cnt", cnt, 0);
      check("mrst_vld", out_vld, 0);
      check("mrst_q", q, 0);
      check("mrst_tag", q_tag, 0);
      cyc();

`ifdef REG_PIPE_PARITY_EN
      // Corrupt the word sitting in stage 2 and watch the sticky flag.
      out_rdy = 1'b0;
      for (int w = 1; w <= 4; w++) begin
         in_vld = 1'b1; data = 64'h1111_0000_0000_0000 * WIDTH'(w);
         cyc();
      end
      in_vld = 1'b0;
      @(negedge clk);
      begin
         logic [WIDTH-1:0] tmp;
         dut.g_stage[2].u_stage.dat[7] = ~dut.g_stage[2].u_stage.dat[7];
         tmp = exp_q[1];
         tmp[7] = ~tmp[7];
         exp_q[1] = tmp;
      end
      check("par_before", par_err, 0);
      cyc();
      out_rdy = 1'b1;
      repeat (3) cyc();
      @(negedge clk);
      check("par_set", par_err, 1);
      drain();
      @(negedge clk);
      check("par_sticky", par_err, 1);
      cyc();
      FL = 1'b1;
      cyc();
      FL = 1'b0;
      @(negedge clk);
      check("par_cleared", par_err, 0);
      cyc();
`else
      @(negedge clk);
      check("par_tied", par_err, 0);
      cyc();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_reg_pipe_elastic
`default_nettype wire
